encap_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one encap_packet datapath between NUM_IN ingress streams, using the NetFPGA data/ctrl/wr/rdy interface.
- Sits directly upstream of encap_packet, so every packet reaching the encapsulator is whole and begins with its IOQ module header.
- Counts forwarded and dropped words/packets per input for software visibility.

---
 rtl/encap_arbiter_pkg.sv | 27 ++
 rtl/encap_arbiter_rr_pick.sv | 39 +++
 rtl/fallthrough_small_fifo.sv | 78 +++++++
 rtl/encap_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_encap_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/encap_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// encap_arbiter_pkg
//   Shared definitions for the encap_arbiter slice: IOQ module header field
//   positions, the ctrl value that marks an IOQ header, arbiter FSM state
//   encodings and statistics counter widths.
// ---------------------------------------------------------------------------
package encap_arbiter_pkg;

    // Field positions inside the IOQ module header word.
    localparam int IOQ_BYTE_LEN_POS = 0;
    localparam int IOQ_WORD_LEN_POS = 48;

    // ctrl value carried by the IOQ module header word.
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;

    // Arbiter state machine.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_t;

    // Statistics counter widths.
    localparam int PKT_CNT_W  = 32;
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/encap_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search. Starting at ptr and walking upward
//   modulo N, returns the first index whose req bit is set.
//
// Ports:
//   req    request vector, one bit per requester
//   ptr    index where the search starts
//   idx    winning index (0 when nothing requests)
//   valid  at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester is the
    // last assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo
//   Small first-word-fall-through FIFO. The head entry is visible on dout
//   combinationally whenever empty is low, so a consumer can inspect and pop
//   in the same cycle. Writes while full are discarded; reads while empty are
//   ignored.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset (empties the FIFO)
//   din          write data
//   wr_en        write strobe
//   rd_en        pop strobe (pops the word currently on dout)
//   dout         head word
//   nearly_full  at most one free entry left
//   empty        no words stored
// ---------------------------------------------------------------------------
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [MAX_DEPTH_BITS:0]   count_reg;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (count_reg == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign nearly_full = (count_reg >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    assign empty       = (count_reg == '0);
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;

    // Storage is read asynchronously so the head falls through with no
    // latency; it is small enough to map to distributed memory.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + MAX_DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + MAX_DEPTH_BITS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (MAX_DEPTH_BITS+1)'(1);
                2'b01:   count_reg <= count_reg - (MAX_DEPTH_BITS+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/encap_arbiter.sv
// ---------------------------------------------------------------------------
// encap_arbiter
//   Packet-granular round-robin arbiter feeding a single encap_packet stage.
//   Each ingress stream is buffered in its own fall-through FIFO; a grant is
//   taken only on a FIFO whose head is an IOQ module header and is held until
//   the end-of-packet word has been forwarded, so downstream only ever sees
//   whole packets. Words found at a FIFO head while idle that are not an IOQ
//   header are orphans and are discarded.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   in_data    flattened ingress data, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl    flattened ingress ctrl, input i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   in_wr      per-input write strobe
//   in_rdy     per-input ready (FIFO not nearly full)
//   out_data   data to encap_packet (0 when out_wr is low)
//   out_ctrl   ctrl to encap_packet (0 when out_wr is low)
//   out_wr     output write strobe
//   out_rdy    encap_packet ready
//   pkt_cnt    per-input forwarded-packet count, 32 bits each, wraps
//   drop_cnt   per-input discarded-word count, 16 bits each, wraps
// ---------------------------------------------------------------------------
module encap_arbiter
    import encap_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH         = 64,
    parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int                    NUM_IN             = 2,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM =
        CTRL_WIDTH'(encap_arbiter_pkg::IO_QUEUE_STAGE_NUM),
    parameter int                    FIFO_DEPTH_BITS    = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0]     in_data,
    input  logic [NUM_IN*CTRL_WIDTH-1:0]     in_ctrl,
    input  logic [NUM_IN-1:0]                in_wr,
    output logic [NUM_IN-1:0]                in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [NUM_IN*PKT_CNT_W-1:0]      pkt_cnt,
    output logic [NUM_IN*DROP_CNT_W-1:0]     drop_cnt
);

    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

    // Per-input FIFO views.
    logic [WORD_W-1:0]     fifo_dout [NUM_IN];
    logic [DATA_WIDTH-1:0] head_data [NUM_IN];
    logic [CTRL_WIDTH-1:0] head_ctrl [NUM_IN];
    logic [NUM_IN-1:0]     fifo_empty;
    logic [NUM_IN-1:0]     fifo_nearly_full;
    logic [NUM_IN-1:0]     fifo_rd_en;
    logic [NUM_IN-1:0]     req_vec;

    // Arbitration state.
    arb_state_t            state_reg,  state_next;
    logic [IDX_W-1:0]      grant_reg,  grant_next;
    logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [CTRL_WIDTH-1:0] gnt_ctrl;
    logic [NUM_IN-1:0]     pkt_inc;
    logic [NUM_IN-1:0]     drop_inc;

    // Statistics.
    logic [PKT_CNT_W-1:0]  pkt_cnt_reg  [NUM_IN];
    logic [DROP_CNT_W-1:0] drop_cnt_reg [NUM_IN];

    // -----------------------------------------------------------------------
    // Per-input buffering, ready and statistics
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            fallthrough_small_fifo #(
                .WIDTH          (WORD_W),
                .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_fifo (
                .clk         (clk),
                .reset_n     (reset_n),
                .din         ({in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH],
                               in_data[gi*DATA_WIDTH +: DATA_WIDTH]}),
                .wr_en       (in_wr[gi]),
                .rd_en       (fifo_rd_en[gi]),
                .dout        (fifo_dout[gi]),
                .nearly_full (fifo_nearly_full[gi]),
                .empty       (fifo_empty[gi])
            );

            assign head_data[gi] = fifo_dout[gi][DATA_WIDTH-1:0];
            assign head_ctrl[gi] = fifo_dout[gi][WORD_W-1:DATA_WIDTH];
            assign in_rdy[gi]    = !fifo_nearly_full[gi];
            assign req_vec[gi]   = !fifo_empty[gi];

            // A FIFO is popped either because its word is being forwarded
            // under the grant or because it is an orphan being discarded.
            assign fifo_rd_en[gi] = (out_wr && (grant_reg == IDX_W'(gi)))
                                  || drop_inc[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pkt_cnt_reg[gi]  <= '0;
                    drop_cnt_reg[gi] <= '0;
                end else begin
                    if (pkt_inc[gi]) begin
                        pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + PKT_CNT_W'(1);
                    end
                    if (drop_inc[gi]) begin
                        drop_cnt_reg[gi] <= drop_cnt_reg[gi] + DROP_CNT_W'(1);
                    end
                end
            end

            assign pkt_cnt[gi*PKT_CNT_W +: PKT_CNT_W]    = pkt_cnt_reg[gi];
            assign drop_cnt[gi*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Candidate selection
    // -----------------------------------------------------------------------
    rr_pick #(
        .N  (NUM_IN),
        .IW (IDX_W)
    ) u_rr_pick (
        .req   (req_vec),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // -----------------------------------------------------------------------
    // Output path: combinational from the granted FIFO head
    // -----------------------------------------------------------------------
    assign gnt_ctrl = head_ctrl[grant_reg];
    assign out_wr   = (state_reg != IDLE) && !fifo_empty[grant_reg] && out_rdy;
    assign out_data = out_wr ? head_data[grant_reg] : '0;
    assign out_ctrl = out_wr ? gnt_ctrl : '0;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        pkt_inc     = '0;
        drop_inc    = '0;

        case (state_reg)
            IDLE: begin
                // One candidate per cycle. Orphan discards do not touch the
                // output, so they proceed even while downstream is stalled.
                if (pick_valid) begin
                    if (head_ctrl[pick_idx] == IO_QUEUE_STAGE_NUM) begin
                        grant_next = pick_idx;
                        state_next = HDR;
                    end else begin
                        drop_inc[pick_idx] = 1'b1;
                    end
                end
            end

            HDR: begin
                // The first ctrl==0 word is the start of payload; it is
                // forwarded now and the FSM moves on in the same cycle.
                if (out_wr && (gnt_ctrl == '0)) begin
                    state_next = PAYLOAD;
                end
            end

            PAYLOAD: begin
                // A non-zero ctrl in payload is the end-of-packet byte mask.
                if (out_wr && (gnt_ctrl != '0)) begin
                    pkt_inc[grant_reg] = 1'b1;
                    rr_ptr_next = (grant_reg == IDX_W'(NUM_IN - 1))
                                ? '0 : grant_reg + IDX_W'(1);
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_encap_arbiter.sv
// ---------------------------------------------------------------------------
// tb_encap_arbiter
//   Directed bench for encap_arbiter (NUM_IN=2, 64-bit data). Inputs are
//   driven on the falling edge; outputs are sampled 1 ns later, well away
//   from the rising edge.
// ---------------------------------------------------------------------------
module tb_encap_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NI = 2;

    localparam logic [7:0] C_HDR = 8'hFF;
    localparam logic [7:0] C_PAY = 8'h00;
    localparam logic [7:0] C_EOP = 8'h10;

    logic              clk;
    logic              reset_n;
    logic [NI*DW-1:0]  in_data;
    logic [NI*CW-1:0]  in_ctrl;
    logic [NI-1:0]     in_wr;
    logic [NI-1:0]     in_rdy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic [NI*32-1:0]  pkt_cnt;
    logic [NI*16-1:0]  drop_cnt;

    int compared   = 0;
    int mismatched = 0;

    encap_arbiter #(
        .DATA_WIDTH      (DW),
        .CTRL_WIDTH      (CW),
        .NUM_IN          (NI),
        .FIFO_DEPTH_BITS (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // Word identity: input, packet letter, word index.
    function automatic logic [63:0] w(int src, int pkt, int idx);
        return 64'hA5A5_0000_0000_0000 | (64'(src) << 16) | (64'(pkt) << 8) | 64'(idx);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write one word into input src for one cycle; called at a falling edge.
    task automatic push(int src, logic [63:0] d, logic [7:0] c);
        in_wr = '0;
        in_wr[src] = 1'b1;
        in_data[src*DW +: DW] = d;
        in_ctrl[src*CW +: CW] = c;
        @(negedge clk);
        in_wr = '0;
    endtask

    // Wait (bounded) for the next forwarded word and compare it.
    task automatic expect_word(string tag, logic [63:0] d, logic [7:0] c);
        int n;
        n = 0;
        #1;
        while (!out_wr && n < 6) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_wr"}, 64'(out_wr), 64'd1);
        if (out_wr) begin
            chk({tag, "_data"}, out_data, d);
            chk({tag, "_ctrl"}, 64'(out_ctrl), 64'(c));
        end
        @(negedge clk);
    endtask

    // Drive input 0 for one cycle and check the output in that cycle.
    task automatic step0(string tag, logic wr, logic [63:0] d, logic [7:0] c,
                         logic ewr, logic [63:0] ed, logic [7:0] ec);
        in_wr[0] = wr;
        in_data[0 +: DW] = d;
        in_ctrl[0 +: CW] = c;
        #1;
        chk({tag, "_wr"}, 64'(out_wr), 64'(ewr));
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_ctrl"}, 64'(out_ctrl), 64'(ec));
        @(negedge clk);
        in_wr = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = '0;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- Reset state ----------------
        #1;
        chk("rst_out_wr",  64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_rdy",  64'(in_rdy), 64'd3);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- Test 1: single packet streamed on input 0 -------
        step0("t1_c0", 1, w(0,1,0), C_HDR, 0, 64'd0, 8'h00);
        step0("t1_bubble", 1, w(0,1,1), C_PAY, 0, 64'd0, 8'h00);
        step0("t1_hdr", 1, w(0,1,2), C_PAY, 1, w(0,1,0), C_HDR);
        step0("t1_p1",  1, w(0,1,3), C_PAY, 1, w(0,1,1), C_PAY);
        step0("t1_p2",  1, w(0,1,4), C_EOP, 1, w(0,1,2), C_PAY);
        step0("t1_p3",  0, 64'd0, 8'h00, 1, w(0,1,3), C_PAY);
        step0("t1_eop", 0, 64'd0, 8'h00, 1, w(0,1,4), C_EOP);
        #1;
        chk("t1_idle_wr", 64'(out_wr), 64'd0);
        chk("t1_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd1);
        chk("t1_rr_ptr", 64'(dut.rr_ptr_reg), 64'd1);
        @(negedge clk);

        // ---------------- Test 2: two packets on each input ---------------
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                in_wr = 2'b11;
                in_data[0 +: DW]  = w(0, 10 + p, k);
                in_data[DW +: DW] = w(1, 10 + p, k);
                in_ctrl[0 +: CW]  = (k == 0) ? C_HDR : (k == 2) ? C_EOP : C_PAY;
                in_ctrl[CW +: CW] = (k == 0) ? C_HDR : (k == 2) ? C_EOP : C_PAY;
                @(negedge clk);
            end
        end
        in_wr = '0;
        out_rdy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 2; s++) begin
                expect_word($sformatf("t2_s%0d_p%0d_h", s, p), w(s, 10 + p, 0), C_HDR);
                expect_word($sformatf("t2_s%0d_p%0d_d", s, p), w(s, 10 + p, 1), C_PAY);
                expect_word($sformatf("t2_s%0d_p%0d_e", s, p), w(s, 10 + p, 2), C_EOP);
            end
        end
        #1;
        chk("t2_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd2);
        chk("t2_pkt_cnt1", 64'(pkt_cnt[32 +: 32]), 64'd2);
        @(negedge clk);

        // ---------------- Test 3: orphan word before a valid packet -------
        out_rdy = 1'b0;
        push(0, w(0,20,9), C_PAY);
        push(0, w(0,20,0), C_HDR);
        push(0, w(0,20,1), C_PAY);
        push(0, w(0,20,2), C_EOP);
        out_rdy = 1'b1;
        expect_word("t3_hdr", w(0,20,0), C_HDR);
        expect_word("t3_pay", w(0,20,1), C_PAY);
        expect_word("t3_eop", w(0,20,2), C_EOP);
        #1;
        chk("t3_drop_cnt0", 64'(drop_cnt[0 +: 16]), 64'd1);
        chk("t3_drop_cnt1", 64'(drop_cnt[16 +: 16]), 64'd0);
        chk("t3_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd3);
        @(negedge clk);

        // ---------------- Test 4: out_rdy 1,0,0,1 during payload ----------
        out_rdy = 1'b0;
        push(0, w(0,30,0), C_HDR);
        for (int k = 1; k <= 3; k++) push(0, w(0,30,k), C_PAY);
        push(0, w(0,30,4), C_EOP);
        out_rdy = 1'b1;
        expect_word("t4_hdr", w(0,30,0), C_HDR);
        expect_word("t4_p1",  w(0,30,1), C_PAY);
        step0("t4_rdy1", 0, 64'd0, 8'h00, 1, w(0,30,2), C_PAY);
        out_rdy = 1'b0;
        step0("t4_rdy0a", 0, 64'd0, 8'h00, 0, 64'd0, 8'h00);
        step0("t4_rdy0b", 0, 64'd0, 8'h00, 0, 64'd0, 8'h00);
        out_rdy = 1'b1;
        step0("t4_rdy1b", 0, 64'd0, 8'h00, 1, w(0,30,3), C_PAY);
        step0("t4_eop",   0, 64'd0, 8'h00, 1, w(0,30,4), C_EOP);
        #1;
        chk("t4_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd4);
        @(negedge clk);

        // ---------------- Test 5: granted FIFO starves mid-packet ---------
        out_rdy = 1'b0;
        push(0, w(0,40,0), C_HDR);
        push(0, w(0,40,1), C_PAY);
        push(0, w(0,40,2), C_PAY);
        push(1, w(1,41,0), C_HDR);
        push(1, w(1,41,1), C_PAY);
        push(1, w(1,41,2), C_EOP);
        out_rdy = 1'b1;
        expect_word("t5_hdr0", w(0,40,0), C_HDR);
        expect_word("t5_p0a",  w(0,40,1), C_PAY);
        expect_word("t5_p0b",  w(0,40,2), C_PAY);
        step0("t5_starve_a", 0, 64'd0, 8'h00, 0, 64'd0, 8'h00);
        step0("t5_starve_b", 0, 64'd0, 8'h00, 0, 64'd0, 8'h00);
        #1;
        chk("t5_grant_held", 64'(dut.grant_reg), 64'd0);
        step0("t5_refill", 1, w(0,40,3), C_EOP, 0, 64'd0, 8'h00);
        expect_word("t5_eop0", w(0,40,3), C_EOP);
        expect_word("t5_hdr1", w(1,41,0), C_HDR);
        expect_word("t5_p1",   w(1,41,1), C_PAY);
        expect_word("t5_eop1", w(1,41,2), C_EOP);
        #1;
        chk("t5_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd5);
        chk("t5_pkt_cnt1", 64'(pkt_cnt[32 +: 32]), 64'd3);
        @(negedge clk);

        // ---------------- Test 6: reset mid-payload -----------------------
        out_rdy = 1'b0;
        push(0, w(0,50,0), C_HDR);
        for (int k = 1; k <= 3; k++) push(0, w(0,50,k), C_PAY);
        push(0, w(0,50,4), C_EOP);
        out_rdy = 1'b1;
        expect_word("t6_hdr", w(0,50,0), C_HDR);
        expect_word("t6_p1",  w(0,50,1), C_PAY);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_wr",    64'(out_wr), 64'd0);
        chk("t6_rst_data",  out_data, 64'd0);
        chk("t6_rst_state", 64'(dut.state_reg), 64'd0);
        chk("t6_rst_pkt",   64'(pkt_cnt), 64'd0);
        chk("t6_rst_drop",  64'(drop_cnt), 64'd0);
        chk("t6_rst_rdy",   64'(in_rdy), 64'd3);
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b0;
        push(1, w(1,60,0), C_HDR);
        push(1, w(1,60,1), C_PAY);
        push(1, w(1,60,2), C_EOP);
        out_rdy = 1'b1;
        expect_word("t6_hdr1", w(1,60,0), C_HDR);
        expect_word("t6_pay1", w(1,60,1), C_PAY);
        expect_word("t6_eop1", w(1,60,2), C_EOP);
        #1;
        chk("t6_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd0);
        chk("t6_pkt_cnt1", 64'(pkt_cnt[32 +: 32]), 64'd1);
        chk("t6_idle_wr",  64'(out_wr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
